hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// Parametrised hazard and forwarding controller for the 5-stage pipelined core (IF/ID/EXE/MEM/WB).
// Holds a shadow scoreboard of in-flight destination registers for EXE, MEM and WB.
// - Detects RAW hazards for the instruction in ID.
// - Issues load-use stalls and registered forwarding selects for EXE.
// - Issues a WB->ID bypass.
// - Flushes wrong-path stages when a branch/jump resolves taken in MEM.
// - Counts stall and flush cycles.
// PARAMETERS
// REG_ADDR_W  5   register address width; register 0 is hard-wired zero, never a hazard
// FWD_EN      1   1: forward and bypass; 0: stall until producer has left WB, all selects stay 00
// LOAD_LAT    1   cycles a load result lags an ALU result (legal 1..2); sets load-use stall length
// CNT_W       32  width of the stall and flush performance counters
// PORTS
// clk            in   1           main clock
// arst_n         in   1           asynchronous active-low reset
// enable         in   1           pipeline advance; 0 freezes all state and counters
// id_valid       in   1           ID holds a real instruction (not a bubble)
// id_rs, id_rt   in   REG_ADDR_W  ID source registers
// id_use_rs/rt   in   1           ID instruction reads rs / rt
// id_rd          in   REG_ADDR_W  ID destination (after RegDst mux)
// id_reg_write   in   1           ID instruction writes the register file
// id_mem_read    in   1           ID instruction is a load
// branch_taken   in   1           instruction in MEM is a taken branch or jump
// stall          out  1           hold PC and IF/ID; ID/EXE loads a bubble
// flush_if_id    out  1           clear IF/ID
// flush_id_exe   out  1           clear ID/EXE
// flush_exe_mem  out  1           clear EXE/MEM control bits
// fwd_sel_a/b    out  2           registered EXE operand select: 00 ID/EXE, 01 EXE/MEM alu, 10 MEM/WB wdata
// id_byp_a/b     out  1           ID/EXE captures WB write data instead of regfile read
// stall_cnt      out  CNT_W       cycles with stall=1, saturating
// flush_cnt      out  CNT_W       cycles with branch_taken=1, saturating
// BEHAVIOUR
// - Reset: all slots invalid; every output 0; fwd_sel 00; counters 0.
// - Slot entry: {valid, rd, reg_write, is_load}. Slots are s1=EXE, s2=MEM, s3=WB.
// - Slot update, each enabled edge: s3<=s2, s2<=s1, and s1<=ID entry, which is a bubble if stall or branch_taken.
// - Match k (per used source): sk.valid & sk.reg_write & sk.rd==src & src!=0. Youngest match (lowest k) wins.
// - Stall, FWD_EN=1: youngest match is a load with k<=LOAD_LAT.
// - Stall, FWD_EN=0: any match in s1..s3.
// - Forward select, FWD_EN=1, decided in ID and registered on the edge ID advances:
//   - youngest match s1 -> 01
//   - youngest match s2 -> 10
//   - no match -> 00
//   - on stall or flush, selects register 00
// - ID bypass (combinational, FWD_EN=1): id_byp=1 when the only match is s3.
// - Flush (combinational): branch_taken -> flush_if_id=flush_id_exe=flush_exe_mem=1; stall forced 0; s1 invalidated.
// - Stall cycles are not counted while a flush is active.
// - Simultaneous flush and stall: flush wins.
// - Two stall cycles for the same instruction (LOAD_LAT=2) are counted twice.
// - enable=0: slots, fwd_sel and counters hold. Combinational outputs still follow inputs but have no effect.
// - Reset mid-stall: all state clears immediately; there are no pending stall or flush remnants.
// - Counters saturate at all-ones, with no wrap.
// STRUCTURE
// - cpu_defines.vh: FWD_NONE=2'b00, FWD_EXE_MEM=2'b01, FWD_MEM_WB=2'b10, and the slot field widths, all shared with cpu.
// - One sub-module, hazard_match: compares one source against s1..s3.
//   It returns the youngest hit index and its is_load bit, and is instantiated twice (rs, rt).
// - Slots are built on reg_arstn_en.
// TESTING
// - add r3,r1,r2 then sub r4,r3,r5 -> no stall; sub enters EXE with fwd_sel_a=01.
// - lw r3; add r4,r3,r3, LOAD_LAT=1 -> exactly 1 stall cycle; then fwd_sel_a=fwd_sel_b=10; stall_cnt=1.
// - Producer to r3, two independent instructions, then a reader of r3 -> id_byp_a=1, fwd_sel_a=00.
// - Write r0 followed by a read of r0 -> no stall, all selects 00.
// - branch_taken while a load-use stall is pending -> stall=0; all three flushes=1; flush_cnt+1; s1 empty next cycle.
// - FWD_EN=0: add r3 then read of r3 -> 3 stall cycles, selects 00; arst_n low mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared forwarding encodings, slot hit indices and helpers
package hazard_scoreboard_pkg;
  localparam int NUM_SLOTS = 3;
  typedef enum logic [1:0] {
    FWD_NONE    = 2'b00,
    FWD_EXE_MEM = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_e;
  typedef enum logic [1:0] {
    HIT_NONE = 2'd0,
    HIT_S1   = 2'd1,
    HIT_S2   = 2'd2,
    HIT_S3   = 2'd3
  } hit_e;
  function automatic fwd_sel_e hit_to_fwd(input hit_e h);
    return h == HIT_S1 ? FWD_EXE_MEM : h == HIT_S2 ? FWD_MEM_WB : FWD_NONE;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one ID source register against the EXE/MEM/WB slots
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]                src,
  input  logic                                 use_src,
  input  logic [NUM_SLOTS-1:0]                 s_valid,
  input  logic [NUM_SLOTS-1:0]                 s_reg_write,
  input  logic [NUM_SLOTS-1:0]                 s_is_load,
  input  logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0] s_rd,
  output hit_e                                 hit,
  output logic                                 hit_load
);
  logic [NUM_SLOTS-1:0] m;
  // per-slot match, register 0 never creates a dependency; youngest slot wins
  always_comb begin
    m = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      m[i] = use_src && src != '0 && s_valid[i] && s_reg_write[i] && s_rd[i] == src;
    hit      = m[0] ? HIT_S1 : m[1] ? HIT_S2 : m[2] ? HIT_S3 : HIT_NONE;
    hit_load = m[0] ? s_is_load[0] : m[1] ? s_is_load[1] : m[2] && s_is_load[2];
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW hazard detection, load-use stall, forwarding and flush control
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_exe,
  output logic                  flush_exe_mem,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam logic [1:0] LOAD_WIN = 2'(LOAD_LAT);
  logic [NUM_SLOTS-1:0]                 valid_q, valid_d, rw_q, rw_d, ld_q, ld_d;
  logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  fwd_sel_e                             fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]                     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  hit_e                                 hit_a, hit_b;
  logic                                 load_a, load_b, hold_a, hold_b;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs (
    .src(id_rs), .use_src(id_valid && id_use_rs), .s_valid(valid_q), .s_reg_write(rw_q),
    .s_is_load(ld_q), .s_rd(rd_q), .hit(hit_a), .hit_load(load_a)
  );
  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rt (
    .src(id_rt), .use_src(id_valid && id_use_rt), .s_valid(valid_q), .s_reg_write(rw_q),
    .s_is_load(ld_q), .s_rd(rd_q), .hit(hit_b), .hit_load(load_b)
  );

  // stall when a load result is not yet forwardable (or any dependency without forwarding); a taken branch overrides
  always_comb begin
    hold_a        = FWD_EN ? load_a && hit_a != HIT_NONE && hit_a <= LOAD_WIN : hit_a != HIT_NONE;
    hold_b        = FWD_EN ? load_b && hit_b != HIT_NONE && hit_b <= LOAD_WIN : hit_b != HIT_NONE;
    stall         = !branch_taken && (hold_a || hold_b);
    flush_if_id   = branch_taken;
    flush_id_exe  = branch_taken;
    flush_exe_mem = branch_taken;
    id_byp_a      = FWD_EN && hit_a == HIT_S3;
    id_byp_b      = FWD_EN && hit_b == HIT_S3;
  end

  // slot shift, registered forward selects and saturating counters; all hold while enable is low
  always_comb begin
    valid_d     = enable ? {valid_q[1], valid_q[0] && !branch_taken, id_valid && !stall && !branch_taken} : valid_q;
    rd_d        = enable ? {rd_q[1:0], id_rd} : rd_q;
    rw_d        = enable ? {rw_q[1:0], id_reg_write} : rw_q;
    ld_d        = enable ? {ld_q[1:0], id_mem_read} : ld_q;
    fwd_a_d     = !enable ? fwd_a_q : (stall || branch_taken || !FWD_EN) ? FWD_NONE : hit_to_fwd(hit_a);
    fwd_b_d     = !enable ? fwd_b_q : (stall || branch_taken || !FWD_EN) ? FWD_NONE : hit_to_fwd(hit_b);
    stall_cnt_d = (enable && stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (enable && branch_taken && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // state register with asynchronous clear
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q     <= '0;
      rd_q        <= '0;
      rw_q        <= '0;
      ld_q        <= '0;
      fwd_a_q     <= FWD_NONE;
      fwd_b_q     <= FWD_NONE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      ld_q        <= ld_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for forwarding and non-forwarding configurations
module tb_hazard_scoreboard;
  logic clk = 0, arst_n = 0, enable = 1, id_valid = 0, id_use_rs = 0, id_use_rt = 0;
  logic id_reg_write = 0, id_mem_read = 0, branch_taken = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0;
  logic a_stall, a_fii, a_fie, a_fem, a_byp_a, a_byp_b;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [3:0] a_scnt, a_fcnt;
  logic b_stall, b_fii, b_fie, b_fem, b_byp_a, b_byp_b;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [31:0] b_scnt, b_fcnt;

  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(1'b1), .LOAD_LAT(1), .CNT_W(4)) dut_a (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(a_stall), .flush_if_id(a_fii),
    .flush_id_exe(a_fie), .flush_exe_mem(a_fem), .fwd_sel_a(a_fwd_a), .fwd_sel_b(a_fwd_b),
    .id_byp_a(a_byp_a), .id_byp_b(a_byp_b), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );
  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(1'b0), .LOAD_LAT(1), .CNT_W(32)) dut_b (
    .clk(clk), .arst_n(arst_n), .enable(enable), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(b_stall), .flush_if_id(b_fii),
    .flush_id_exe(b_fie), .flush_exe_mem(b_fem), .fwd_sel_a(b_fwd_a), .fwd_sel_b(b_fwd_b),
    .id_byp_a(b_byp_a), .id_byp_b(b_byp_b), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int at; int sig; logic [31:0] val; string nm;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  logic done = 0;
  logic [31:0] got;

  function automatic logic [31:0] getsig(input int s);
    case (s)
      0: return 32'(a_stall);
      1: return 32'(a_fii);
      2: return 32'(a_fie);
      3: return 32'(a_fem);
      4: return 32'(a_fwd_a);
      5: return 32'(a_fwd_b);
      6: return 32'(a_byp_a);
      7: return 32'(a_byp_b);
      8: return 32'(a_scnt);
      9: return 32'(a_fcnt);
      10: return 32'(b_stall);
      11: return 32'(b_fwd_a);
      12: return b_scnt;
      13: return 32'(|{a_stall, a_fii, a_fie, a_fem, a_fwd_a, a_fwd_b, a_byp_a, a_byp_b, a_scnt, a_fcnt,
                       b_stall, b_fii, b_fie, b_fem, b_fwd_a, b_fwd_b, b_byp_a, b_byp_b, b_scnt, b_fcnt});
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input logic [31:0] val, input string nm);
    q.push_back('{at, sig, val, nm});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = ld;
  endtask
  task automatic bubble(input int n);
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_reg_write = 0; id_mem_read = 0;
    repeat (n) step();
  endtask

  // monitor: pop every expectation due this cycle and compare it against the DUT outputs
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      got = getsig(e.sig);
      n_cmp++;
      if (e.at != cyc || got !== e.val) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)", e.nm, got, e.val, cyc, e.at);
      end
    end
    if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: never checked, expected %0d", e.nm, e.val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    step(); step();
    arst_n = 1;
    step();
    expect_at(cyc, 13, 0, "reset_outputs");
    expect_at(cyc, 8, 0, "reset_stall_cnt");
    expect_at(cyc, 9, 0, "reset_flush_cnt");
    // add r3,r1,r2 ; sub r4,r3,r5
    instr(1, 2, 1, 1, 3, 1, 0);
    expect_at(cyc, 0, 0, "alu_producer_nostall");
    step();
    instr(3, 5, 1, 1, 4, 1, 0);
    expect_at(cyc, 0, 0, "alu_consumer_nostall");
    expect_at(cyc, 6, 0, "alu_consumer_no_byp");
    expect_at(cyc + 1, 4, 1, "alu_fwd_a_exe_mem");
    expect_at(cyc + 1, 5, 0, "alu_fwd_b_none");
    step();
    bubble(3);
    // lw r3 ; add r4,r3,r3
    instr(1, 0, 1, 0, 3, 1, 1);
    step();
    instr(3, 3, 1, 1, 4, 1, 0);
    expect_at(cyc, 0, 1, "load_use_stall");
    expect_at(cyc + 1, 4, 0, "load_use_fwd_bubble");
    step();
    expect_at(cyc, 0, 0, "load_use_released");
    expect_at(cyc, 8, 1, "load_use_stall_cnt");
    expect_at(cyc + 1, 4, 2, "load_use_fwd_a_mem_wb");
    expect_at(cyc + 1, 5, 2, "load_use_fwd_b_mem_wb");
    step();
    bubble(3);
    // producer r3, two independent, reader of r3
    instr(1, 2, 1, 1, 3, 1, 0); step();
    instr(1, 2, 1, 1, 6, 1, 0); step();
    instr(1, 2, 1, 1, 7, 1, 0); step();
    instr(3, 0, 1, 1, 8, 1, 0);
    expect_at(cyc, 6, 1, "wb_bypass_a");
    expect_at(cyc, 7, 0, "wb_bypass_b_r0");
    expect_at(cyc, 0, 0, "wb_bypass_nostall");
    expect_at(cyc + 1, 4, 0, "wb_bypass_fwd_a_none");
    step();
    bubble(3);
    // write r0 then read r0
    instr(1, 2, 1, 1, 0, 1, 1); step();
    instr(0, 0, 1, 1, 5, 1, 0);
    expect_at(cyc, 0, 0, "r0_nostall");
    expect_at(cyc, 6, 0, "r0_no_byp");
    expect_at(cyc + 1, 4, 0, "r0_fwd_a_none");
    expect_at(cyc + 1, 5, 0, "r0_fwd_b_none");
    step();
    bubble(3);
    // taken branch while load-use stall is pending
    instr(1, 0, 1, 0, 3, 1, 1); step();
    instr(3, 3, 1, 1, 4, 1, 0);
    branch_taken = 1;
    expect_at(cyc, 0, 0, "flush_kills_stall");
    expect_at(cyc, 1, 1, "flush_if_id");
    expect_at(cyc, 2, 1, "flush_id_exe");
    expect_at(cyc, 3, 1, "flush_exe_mem");
    step();
    branch_taken = 0;
    expect_at(cyc, 0, 0, "flush_s1_empty");
    expect_at(cyc, 1, 0, "flush_released");
    expect_at(cyc, 9, 1, "flush_cnt_one");
    expect_at(cyc, 8, 1, "flush_stall_cnt_hold");
    expect_at(cyc, 4, 0, "flush_fwd_a_none");
    step();
    bubble(3);
    // enable low freezes slots and counters
    instr(1, 0, 1, 0, 3, 1, 1); step();
    instr(3, 0, 1, 0, 4, 1, 0);
    enable = 0;
    expect_at(cyc, 0, 1, "frozen_stall_visible");
    step();
    expect_at(cyc, 0, 1, "frozen_stall_held");
    expect_at(cyc, 8, 1, "frozen_stall_cnt");
    enable = 1;
    step();
    expect_at(cyc, 8, 2, "resumed_stall_cnt");
    expect_at(cyc, 0, 0, "resumed_stall_done");
    step();
    bubble(3);
    // flush counter saturation
    branch_taken = 1;
    repeat (13) step();
    expect_at(cyc, 9, 14, "flush_cnt_pre_sat");
    repeat (3) step();
    expect_at(cyc, 9, 15, "flush_cnt_saturated");
    branch_taken = 0;
    bubble(2);
    // non-forwarding configuration
    arst_n = 0;
    step();
    arst_n = 1;
    bubble(1);
    instr(1, 2, 1, 1, 3, 1, 0); step();
    instr(3, 1, 1, 1, 4, 1, 0);
    expect_at(cyc, 10, 1, "nofwd_stall_1");
    step();
    expect_at(cyc, 10, 1, "nofwd_stall_2");
    expect_at(cyc, 11, 0, "nofwd_fwd_a_stalled");
    step();
    expect_at(cyc, 10, 1, "nofwd_stall_3");
    step();
    expect_at(cyc, 10, 0, "nofwd_released");
    expect_at(cyc, 12, 3, "nofwd_stall_cnt");
    expect_at(cyc + 1, 11, 0, "nofwd_fwd_a_none");
    step();
    bubble(3);
    // reset in the middle of a stall
    instr(1, 2, 1, 1, 3, 1, 0); step();
    instr(3, 1, 1, 1, 4, 1, 0);
    expect_at(cyc, 10, 1, "pre_reset_stall");
    step();
    arst_n = 0;
    #1;
    expect_at(cyc, 13, 0, "mid_stall_reset_outputs");
    expect_at(cyc, 12, 0, "mid_stall_reset_cnt");
    step();
    arst_n = 1;
    bubble(2);
    done = 1;
    repeat (10) @(posedge clk);
    $display("FAIL watchdog: monitor did not finish");
    $fatal(1);
  end
endmodule
